lif_membrane_integrator: RTL
============================

# lif_membrane_integrator

Leaky integrate-and-fire state stage wrapped around the decay stage. It owns the membrane-potential register `u` and drives `u` and `shift` out to the combinational decay stage. It takes the decayed value `beta_u` back, adds the synaptic current accumulated since the last timestep, and compares against threshold. It emits a one-cycle spike, resets the potential and enforces a refractory period.

## Interface
- `N_STAGE`, default 10. Potential width is `W = N_STAGE+2` (12 bits), unsigned.
- `REFRAC_W`, default 4. Width of the refractory counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `step` input 1: timestep strobe, one-cycle pulse.
- `cur_valid` input 1: synaptic current beat valid.
- `cur_ready` output 1: integrator accepts a beat.
- `cur_in` input W: synaptic current magnitude, unsigned.
- `threshold` input W: firing threshold. 0 disables firing.
- `reset_mode` input 1: 0 = reset to zero, 1 = subtract threshold.
- `refrac_len` input REFRAC_W: refractory length, in timesteps.
- `shift_cfg` input 3: leak shift amount.
- `u_out` output W: current potential, fed to the decay stage.
- `shift_out` output 3: registered `shift_cfg`, fed to the decay stage.
- `beta_u_in` input W: decayed potential returned from the decay stage.
- `spike` output 1: one-cycle spike pulse.
- `step_miss` output 1: pulse; a `step` arrived in FIRE and was dropped.

## Operation
- States: IDLE, FIRE, REFRAC. Reset state is IDLE.
- Reset values: `u`=0, `acc`=0, `shift_out`=0, refractory counter=0, `spike`=0, `step_miss`=0.
- `shift_out` samples `shift_cfg` on every `step` while in IDLE. It is constant between steps.
- Accumulation:
  - `cur_ready` is 1 in IDLE and REFRAC, and 0 in FIRE.
  - Each handshake (`cur_valid && cur_ready`) does `acc <= sat(acc + cur_in)`, saturating at 2^W−1.
- IDLE with `step`:
  - Compute `sum = sat(beta_u_in + acc + beat)`. `beat` is `cur_in` if a handshake occurs in the same cycle, else 0.
  - Clear `acc`.
  - If `threshold != 0` and `sum >= threshold`, go to FIRE and load `u <= sum`.
  - Otherwise load `u <= sum` and stay in IDLE.
- FIRE (exactly one cycle):
  - `spike=1`.
  - `u <= 0` if `reset_mode==0`, else `u <= u − threshold`. This cannot underflow because `u >= threshold`.
  - Load the refractory counter with `refrac_len`.
  - Next state is REFRAC if `refrac_len != 0`, else IDLE.
  - A `step` in this cycle is dropped and `step_miss` pulses in the same cycle.
- REFRAC:
  - `u` is held and is not decayed.
  - Handshakes are accepted, but `acc` is held at 0 (beats are discarded).
  - Each `step` decrements the counter. The `step` that brings it to 0 returns the block to IDLE; that step does not integrate.
- With `threshold==0` the block never leaves IDLE. It behaves as a pure leaky integrator.

## Timing
- `spike` rises in the cycle after the crossing `step` (latency 1). It lasts one cycle.
- `u_out` updates at the clock edge of the `step` cycle. The decay stage sees the new `u` in the following cycle.
- A `step` in IDLE is honoured even in the cycle immediately after a previous `step`.
- Simultaneous `step` and handshake in IDLE: the beat is included in `sum` and is not carried into the next `acc`.
- `rst_n` asserted mid-operation forces all registers to their reset values immediately. Any in-flight spike or refractory period is abandoned.
- `cur_valid` held high in FIRE: the beat is stalled, not lost. It is accepted in the next cycle.

## Structure
- Shared package (`snn_pkg`) holds:
  - the state enum {IDLE, FIRE, REFRAC};
  - the `W` derivation;
  - a `sat_add` function used by the accumulator and by `sum`.
- The decay stage stays an external instance. It is wired at the neuron top, not inside this block.
- One sub-module is natural: `refrac_counter` (load, decrement-on-step, zero flag).

## Test plan
- Leak only:
  - Stimulus: `u`=100, `shift_cfg`=1, decay stage returns 50, no current, one `step`, `threshold`=0.
  - Required: `u_out`=50, no spike.
- Integrate:
  - Stimulus: three beats of 30 between steps, decay returns 50, `threshold`=200.
  - Required: `u`=140, no spike.
  - A further step with `beta_u_in`=150 and acc=60 gives sum 210: `spike`=1 one cycle later, then `u`=0.
- Subtract reset:
  - Stimulus: `reset_mode`=1, sum=250, `threshold`=200.
  - Required: spike, `u`=50.
- Refractory:
  - Stimulus: `refrac_len`=2 after a spike; two steps with beats of 100 in between.
  - Required: `u` held at 0, no spike. The third step integrates normally.
- Saturation / same-cycle:
  - Stimulus: `acc`=4000, beat of 200 in the same cycle as `step`, `beta_u_in`=0.
  - Required: `u`=4095 and `acc`=0.
- Dropped step / async reset:
  - Stimulus: `step` during FIRE.
  - Required: `step_miss`=1, state unchanged.
  - Stimulus: `rst_n` low mid-REFRAC.
  - Required: IDLE and `u`=0 before the next clock edge.

Source files
------------

// File: rtl/lif_membrane_integrator_pkg.sv
// ---------------------------------------------------------------------------
// Module : snn_pkg
// Shared types, width derivation and saturating add for the LIF neuron.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

    localparam int SAT_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_REFRAC = 2'd2
    } lif_state_e;

    function automatic int lif_width(input int n_stage);
        return n_stage + 2;
    endfunction

    // Unsigned add clamped to 2^w-1; valid for w < SAT_MAX_W.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W:0] s;
        logic [SAT_MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        return (s > lim) ? lim[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_membrane_integrator_if.sv
// ---------------------------------------------------------------------------
// Module : lif_cur_if
// Synaptic current valid/ready stream into the membrane integrator.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lif_cur_if #(
    parameter int W = 12
) ();
    logic         cur_valid;
    logic         cur_ready;
    logic [W-1:0] cur_in;

    modport master (output cur_valid, output cur_in, input  cur_ready);
    modport slave  (input  cur_valid, input  cur_in, output cur_ready);
endinterface

`default_nettype wire

// File: rtl/lif_membrane_integrator_refrac_counter.sv
// ---------------------------------------------------------------------------
// Module : refrac_counter
// Refractory down-counter: load, decrement per timestep, zero/expire flags.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module refrac_counter #(
    parameter int REFRAC_W = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_load,
    input  wire logic [REFRAC_W-1:0] i_load_val,
    input  wire logic                i_dec,
    output logic                     o_zero,
    output logic                     o_expire
);

    logic [REFRAC_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - REFRAC_W'(1);
        end
    end

    assign o_zero   = (r_count == '0);
    // High on the decrement that lands the count on zero.
    assign o_expire = i_dec && (r_count <= REFRAC_W'(1));

endmodule

`default_nettype wire

// File: rtl/lif_membrane_integrator.sv
// ---------------------------------------------------------------------------
// Module : lif_membrane_integrator
// LIF state stage: owns potential u, integrates current, fires, refracts.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lif_membrane_integrator
    import snn_pkg::*;
#(
    parameter  int N_STAGE  = 10,
    parameter  int REFRAC_W = 4,
    localparam int W        = lif_width(N_STAGE)
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                step,
    lif_cur_if.slave                 cur,
    input  wire logic [W-1:0]        threshold,
    input  wire logic                reset_mode,
    input  wire logic [REFRAC_W-1:0] refrac_len,
    input  wire logic [2:0]          shift_cfg,
    output logic      [W-1:0]        u_out,
    output logic      [2:0]          shift_out,
    input  wire logic [W-1:0]        beta_u_in,
    output logic                     spike,
    output logic                     step_miss
);

    lif_state_e   r_state, w_state_next;
    logic [W-1:0] r_u, w_u_next;
    logic [W-1:0] r_acc, w_acc_next;
    logic [2:0]   r_shift, w_shift_next;
    logic         w_hs;
    logic [W-1:0] w_beat;
    logic [W-1:0] w_acc_add;
    logic [W-1:0] w_sum;
    logic         w_load, w_dec;
    logic         w_cnt_zero, w_cnt_expire;
    logic         w_spike, w_step_miss;

    assign cur.cur_ready = (r_state != ST_FIRE);
    assign w_hs          = cur.cur_valid && cur.cur_ready;
    assign w_beat        = w_hs ? cur.cur_in : '0;
    assign w_acc_add     = W'(sat_add(32'(r_acc), 32'(cur.cur_in), W));
    // Same-cycle beat joins the sum directly rather than going through acc.
    assign w_sum         = W'(sat_add(sat_add(32'(beta_u_in), 32'(r_acc), W),
                                      32'(w_beat), W));

    refrac_counter #(
        .REFRAC_W (REFRAC_W)
    ) u_refrac_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (refrac_len),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero),
        .o_expire   (w_cnt_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_u     <= '0;
            r_acc   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_u     <= w_u_next;
            r_acc   <= w_acc_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_u_next     = r_u;
        w_acc_next   = r_acc;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_spike      = 1'b0;
        w_step_miss  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_acc_next = w_acc_add;
                end
                if (step) begin
                    w_acc_next   = '0;
                    w_u_next     = w_sum;
                    w_shift_next = shift_cfg;
                    if ((threshold != '0) && (w_sum >= threshold)) begin
                        w_state_next = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                w_spike     = 1'b1;
                w_step_miss = step;
                w_load      = 1'b1;
                w_u_next    = reset_mode ? (r_u - threshold) : '0;
                w_state_next = (refrac_len != '0) ? ST_REFRAC : ST_IDLE;
            end
            ST_REFRAC: begin
                w_acc_next = '0;
                w_dec      = step;
                if (w_cnt_zero || w_cnt_expire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign u_out     = r_u;
    assign shift_out = r_shift;
    assign spike     = w_spike;
    assign step_miss = w_step_miss;

endmodule

`default_nettype wire
